// File: rtl/sprite_fetch_arbiter.sv
// Round-robin arbiter for three reel fetchers sharing one sprite ROM.
// Grants are combinational; address and response tags are pipelined two deep.
module sprite_fetch_arbiter #(
  parameter int          NUM_SYMBOLS = 8,
  parameter logic [23:0] FILL_COLOR  = 24'h000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [2:0]  req,
  input  logic [11:0] sym,
  input  logic [20:0] px_x,
  input  logic [20:0] px_y,
  output logic [2:0]  ack,
  output logic [16:0] rom_addr,
  input  logic [23:0] rom_pixel,
  output logic        rsp_valid,
  output logic [1:0]  rsp_id,
  output logic [23:0] rsp_pixel,
  output logic        rsp_err
);

  logic [1:0]  last_grant;
  logic [1:0]  grant_idx;
  logic        grant_any;
  logic [1:0]  probe;
  logic [3:0]  sel_sym;
  logic [6:0]  sel_x;
  logic [6:0]  sel_y;
  logic        sym_ok;
  logic        s1_valid;
  logic [1:0]  s1_id;
  logic        s1_err;

  function automatic logic [1:0] next_reel(input logic [1:0] r);
    return (r == 2'd2) ? 2'd0 : r + 2'd1;
  endfunction

  function automatic logic req_at(input logic [2:0] r, input logic [1:0] i);
    case (i)
      2'd0:    return r[0];
      2'd1:    return r[1];
      default: return r[2];
    endcase
  endfunction

  // Search starts one past the previous winner so every reel gets a turn.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = 2'd0;
    probe     = next_reel(last_grant);
    if (rst_n && enable) begin
      for (int i = 0; i < 3; i++) begin
        if (!grant_any && req_at(req, probe)) begin
          grant_any = 1'b1;
          grant_idx = probe;
        end
        probe = next_reel(probe);
      end
    end
  end

  assign ack = grant_any ? (3'b001 << grant_idx) : 3'b000;

  always_comb begin
    sel_sym = sym[3:0];
    sel_x   = px_x[6:0];
    sel_y   = px_y[6:0];
    case (grant_idx)
      2'd1: begin
        sel_sym = sym[7:4];
        sel_x   = px_x[13:7];
        sel_y   = px_y[13:7];
      end
      2'd2: begin
        sel_sym = sym[11:8];
        sel_x   = px_x[20:14];
        sel_y   = px_y[20:14];
      end
      default: ;
    endcase
  end

  assign sym_ok = ({28'd0, sel_sym} < NUM_SYMBOLS);

  // Rejected symbols leave rom_addr untouched; the error tag carries them through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 2'd2;
      rom_addr   <= 17'd0;
      s1_valid   <= 1'b0;
      s1_id      <= 2'd0;
      s1_err     <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 2'd0;
      rsp_err    <= 1'b0;
    end else begin
      if (grant_any) begin
        last_grant <= grant_idx;
        if (sym_ok) begin
          rom_addr <= {sel_sym[2:0], sel_y, sel_x};
        end
      end
      s1_valid  <= grant_any;
      s1_id     <= grant_idx;
      s1_err    <= grant_any & ~sym_ok;
      rsp_valid <= s1_valid;
      rsp_id    <= s1_id;
      rsp_err   <= s1_err;
    end
  end

  assign rsp_pixel = rsp_err ? FILL_COLOR : rom_pixel;

endmodule

// File: tb/tb_sprite_fetch_arbiter.sv
// Scoreboard bench for sprite_fetch_arbiter with a one-cycle-latency ROM model.
module tb_sprite_fetch_arbiter;

  localparam logic [23:0] TB_FILL = 24'hC0FFEE;

  typedef struct packed {
    logic [1:0]  id;
    logic        err;
    logic [23:0] pixel;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b0;
  logic [2:0]  req = 3'b000;
  logic [11:0] sym = 12'd0;
  logic [20:0] px_x = 21'd0;
  logic [20:0] px_y = 21'd0;
  logic [2:0]  ack;
  logic [16:0] rom_addr;
  logic [23:0] rom_pixel;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [23:0] rsp_pixel;
  logic        rsp_err;

  int   errors = 0;
  int   checks = 0;
  rsp_t sb[$];

  sprite_fetch_arbiter #(.NUM_SYMBOLS(8), .FILL_COLOR(TB_FILL)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .req(req), .sym(sym),
    .px_x(px_x), .px_y(px_y), .ack(ack), .rom_addr(rom_addr),
    .rom_pixel(rom_pixel), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_pixel(rsp_pixel), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] rom_word(input logic [16:0] a);
    return {7'h5A, a};
  endfunction

  function automatic logic [16:0] addr_of(input int s, input int x, input int y);
    return 17'(s * 16384 + y * 128 + x);
  endfunction

  always @(posedge clk) rom_pixel <= rom_word(rom_addr);

  // Every response is matched in order against what the stimulus expected.
  always @(negedge clk) begin
    rsp_t e;
    if (rsp_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_rsp: got id=%0d err=%0b pixel=%h, required no response",
                 rsp_id, rsp_err, rsp_pixel);
      end else begin
        e = sb.pop_front();
        if ({rsp_id, rsp_err, rsp_pixel} !== e) begin
          errors++;
          $display("[TB] FAIL rsp_match: got id=%0d err=%0b pixel=%h, required id=%0d err=%0b pixel=%h",
                   rsp_id, rsp_err, rsp_pixel, e.id, e.err, e.pixel);
        end
      end
    end
  end

  task automatic set_reel(input int k, input int s, input int x, input int y);
    sym[k*4 +: 4]  = 4'(s);
    px_x[k*7 +: 7] = 7'(x);
    px_y[k*7 +: 7] = 7'(y);
  endtask

  task automatic push_rsp(input int id, input logic err, input logic [23:0] pix);
    rsp_t e;
    e.id    = 2'(id);
    e.err   = err;
    e.pixel = pix;
    sb.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && sb.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    enable = 1'b1;
    req    = 3'b111;
    #1;
    checks++;
    if (ack !== 3'b000) begin errors++; $display("[TB] FAIL reset_ack: got %b, required 000", ack); end
    checks++;
    if (rom_addr !== 17'd0) begin errors++; $display("[TB] FAIL reset_addr: got %h, required 0", rom_addr); end
    checks++;
    if ({rsp_valid, rsp_id, rsp_err} !== 4'b0) begin
      errors++;
      $display("[TB] FAIL reset_rsp: got v=%b id=%0d err=%b, required all 0", rsp_valid, rsp_id, rsp_err);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_ack [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
    int         exp_id  [4] = '{0, 1, 2, 0};
    for (int k = 0; k < 3; k++) set_reel(k, k + 1, 10 * k + 1, k + 4);
    req = 3'b111;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (ack !== exp_ack[c]) begin
        errors++;
        $display("[TB] FAIL rr_ack%0d: got %b, required %b", c, ack, exp_ack[c]);
      end
      push_rsp(exp_id[c], 1'b0, rom_word(addr_of(exp_id[c] + 1, 10 * exp_id[c] + 1, exp_id[c] + 4)));
      @(negedge clk);
    end
    req = 3'b000;
    drain();
    checks++;
    if (sb.size() != 0) begin errors++; $display("[TB] FAIL rr_drain: got %0d pending, required 0", sb.size()); end
  endtask

  task automatic test_single_reel();
    set_reel(1, 2, 5, 3);
    req = 3'b010;
    #1;
    checks++;
    if (ack !== 3'b010) begin errors++; $display("[TB] FAIL single_ack: got %b, required 010", ack); end
    push_rsp(1, 1'b0, rom_word(17'h08185));
    @(negedge clk);
    req = 3'b000;
    checks++;
    if (rom_addr !== 17'h08185) begin errors++; $display("[TB] FAIL single_addr: got %h, required 08185", rom_addr); end
    drain();
    checks++;
    if (sb.size() != 0) begin errors++; $display("[TB] FAIL single_drain: got %0d pending, required 0", sb.size()); end
  endtask

  task automatic test_fill();
    set_reel(2, 9, 20, 30);
    req = 3'b100;
    #1;
    checks++;
    if (ack !== 3'b100) begin errors++; $display("[TB] FAIL fill_ack: got %b, required 100", ack); end
    push_rsp(2, 1'b1, TB_FILL);
    @(negedge clk);
    req = 3'b000;
    checks++;
    if (rom_addr !== 17'h08185) begin errors++; $display("[TB] FAIL fill_addr_hold: got %h, required 08185", rom_addr); end
    drain();
    checks++;
    if (sb.size() != 0) begin errors++; $display("[TB] FAIL fill_drain: got %0d pending, required 0", sb.size()); end
  endtask

  task automatic test_back_to_back();
    set_reel(0, 7, 127, 127);
    set_reel(1, 0, 0, 0);
    req = 3'b001;
    #1;
    checks++;
    if (ack !== 3'b001) begin errors++; $display("[TB] FAIL b2b_ack0: got %b, required 001", ack); end
    push_rsp(0, 1'b0, rom_word(17'h1FFFF));
    @(negedge clk);
    req = 3'b010;
    checks++;
    if (rom_addr !== 17'h1FFFF) begin errors++; $display("[TB] FAIL addr_max: got %h, required 1FFFF", rom_addr); end
    #1;
    checks++;
    if (ack !== 3'b010) begin errors++; $display("[TB] FAIL b2b_ack1: got %b, required 010", ack); end
    push_rsp(1, 1'b0, rom_word(17'h00000));
    @(negedge clk);
    req = 3'b000;
    checks++;
    if (rom_addr !== 17'h00000) begin errors++; $display("[TB] FAIL addr_min: got %h, required 00000", rom_addr); end
    drain();
    checks++;
    if (sb.size() != 0) begin errors++; $display("[TB] FAIL b2b_drain: got %0d pending, required 0", sb.size()); end
  endtask

  task automatic test_enable_drop();
    int pulses = 0;
    for (int k = 0; k < 3; k++) set_reel(k, k + 1, k + 2, k + 3);
    enable = 1'b1;
    req    = 3'b111;
    #1;
    checks++;
    if (ack !== 3'b100) begin errors++; $display("[TB] FAIL en_ack0: got %b, required 100", ack); end
    push_rsp(2, 1'b0, rom_word(addr_of(3, 4, 5)));
    @(negedge clk);
    #1;
    checks++;
    if (ack !== 3'b001) begin errors++; $display("[TB] FAIL en_ack1: got %b, required 001", ack); end
    push_rsp(0, 1'b0, rom_word(addr_of(1, 2, 3)));
    @(negedge clk);
    enable = 1'b0;
    for (int c = 0; c < 6; c++) begin
      #1;
      checks++;
      if (ack !== 3'b000) begin errors++; $display("[TB] FAIL en_blocked%0d: got %b, required 000", c, ack); end
      if (rsp_valid === 1'b1) pulses++;
      @(negedge clk);
    end
    checks++;
    if (pulses != 2) begin errors++; $display("[TB] FAIL en_pulses: got %0d, required 2", pulses); end
    enable = 1'b1;
    #1;
    checks++;
    if (ack !== 3'b010) begin errors++; $display("[TB] FAIL en_resume: got %b, required 010", ack); end
    push_rsp(1, 1'b0, rom_word(addr_of(2, 3, 4)));
    @(negedge clk);
    req = 3'b000;
    drain();
    checks++;
    if (sb.size() != 0) begin errors++; $display("[TB] FAIL en_drain: got %0d pending, required 0", sb.size()); end
  endtask

  task automatic test_drop_req();
    enable = 1'b0;
    req    = 3'b001;
    #1;
    checks++;
    if (ack !== 3'b000) begin errors++; $display("[TB] FAIL drop_ack: got %b, required 000", ack); end
    @(negedge clk);
    req    = 3'b000;
    enable = 1'b1;
    drain();
    checks++;
    if (sb.size() != 0) begin errors++; $display("[TB] FAIL drop_drain: got %0d pending, required 0", sb.size()); end
  endtask

  task automatic test_reset_midop();
    set_reel(2, 4, 1, 1);
    set_reel(0, 5, 2, 9);
    req = 3'b100;
    #1;
    checks++;
    if (ack !== 3'b100) begin errors++; $display("[TB] FAIL mid_ack: got %b, required 100", ack); end
    @(negedge clk);
    req = 3'b000;
    #1;
    checks++;
    if (rom_addr !== 17'h10081) begin errors++; $display("[TB] FAIL mid_addr: got %h, required 10081", rom_addr); end
    #1;
    req   = 3'b111;
    rst_n = 1'b0;
    #1;
    checks++;
    if (rom_addr !== 17'd0) begin errors++; $display("[TB] FAIL mid_reset_addr: got %h, required 0", rom_addr); end
    checks++;
    if ({rsp_valid, rsp_id, rsp_err, ack} !== 7'b0) begin
      errors++;
      $display("[TB] FAIL mid_reset_out: got v=%b id=%0d err=%b ack=%b, required all 0",
               rsp_valid, rsp_id, rsp_err, ack);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_no_rsp: got %b, required 0", rsp_valid); end
    rst_n = 1'b1;
    #1;
    checks++;
    if (ack !== 3'b001) begin errors++; $display("[TB] FAIL mid_first_grant: got %b, required 001", ack); end
    push_rsp(0, 1'b0, rom_word(addr_of(5, 2, 9)));
    @(negedge clk);
    req = 3'b000;
    drain();
    checks++;
    if (sb.size() != 0) begin errors++; $display("[TB] FAIL mid_drain: got %0d pending, required 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_reel();
    test_fill();
    test_back_to_back();
    test_enable_drop();
    test_drop_req();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

endmodule
